// File: rtl/sevenseg_scan.sv
// Time-multiplexed driver for DIGITS common-anode seven-segment digits with tear-free value updates.
// Optional leading-zero blanking: define SEVENSEG_SCAN_LZ_BLANK_EN.
module sevenseg_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic                  load_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  enable_i,
    output logic [6:0]            seg_no,
    output logic                  dp_no,
    output logic [DIGITS-1:0]     an_no,
    output logic                  frame_o
);
    localparam int PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NSLOT = 1 << IW;
    localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

    logic [PW-1:0]         pcnt_reg;
    logic [IW-1:0]         idx_reg;
    logic [4*DIGITS-1:0]   pend_val_reg, disp_val_reg;
    logic [DIGITS-1:0]     pend_dp_reg, disp_dp_reg;
    logic                  wrap_reg, frame_reg;
    logic [DIGITS-1:0]     an_reg;
    logic [6:0]            seg_reg;
    logic                  dp_reg;

    logic                  tc, wrap;
    logic [DIGITS-1:0]     an_sel, an_next;
    logic [6:0]            glyph, seg_next;
    logic                  dp_next, lit;

    // Index space is padded to a power of two so idx_reg can select without range checks.
    logic [3:0]            nib [NSLOT];
    logic [NSLOT-1:0]      dp_slot, dark_slot;

    assign tc   = (pcnt_reg == PCNT_MAX);
    assign wrap = tc && (idx_reg == IDX_MAX);

`ifdef SEVENSEG_SCAN_LZ_BLANK_EN
    // upper_zero[k]: nibbles k..DIGITS-1 of the displayed value are all zero
    logic [DIGITS:0] upper_zero;
    assign upper_zero[DIGITS] = 1'b1;
`endif

    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
        if (gi < DIGITS) begin : g_real
            assign nib[gi]     = disp_val_reg[4*gi +: 4];
            assign dp_slot[gi] = disp_dp_reg[gi];
            assign an_sel[gi]  = (idx_reg == IW'(gi));
`ifdef SEVENSEG_SCAN_LZ_BLANK_EN
            assign upper_zero[gi] = (disp_val_reg[4*gi +: 4] == 4'h0) && upper_zero[gi+1];
            if (gi == 0) begin : g_lsd
                assign dark_slot[gi] = 1'b0;
            end else begin : g_msd
                assign dark_slot[gi] = upper_zero[gi] && !disp_dp_reg[gi];
            end
`else
            assign dark_slot[gi] = 1'b0;
`endif
        end else begin : g_pad
            assign nib[gi]       = 4'h0;
            assign dp_slot[gi]   = 1'b0;
            assign dark_slot[gi] = 1'b1;
        end
    end

    // Active-low glyphs, bit 0 = segment A .. bit 6 = segment G
    always_comb begin
        glyph = 7'h7F;
        case (nib[idx_reg])
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

    always_comb begin
        lit      = enable_i && !dark_slot[idx_reg];
        an_next  = '1;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (lit) begin
            an_next  = ~an_sel;
            seg_next = glyph;
            dp_next  = ~dp_slot[idx_reg];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt_reg     <= '0;
            idx_reg      <= '0;
            pend_val_reg <= '0;
            pend_dp_reg  <= '0;
            disp_val_reg <= '0;
            disp_dp_reg  <= '0;
            wrap_reg     <= 1'b0;
            frame_reg    <= 1'b0;
            an_reg       <= '1;
            seg_reg      <= 7'h7F;
            dp_reg       <= 1'b1;
        end else begin
            pcnt_reg <= tc ? '0 : pcnt_reg + PW'(1);
            if (tc) begin
                idx_reg <= wrap ? '0 : idx_reg + IW'(1);
            end
            if (load_i) begin
                pend_val_reg <= value_i;
                pend_dp_reg  <= dp_i;
            end
            // A load on the wrap cycle bypasses the pending registers so it is not a frame late.
            if (wrap) begin
                disp_val_reg <= load_i ? value_i : pend_val_reg;
                disp_dp_reg  <= load_i ? dp_i : pend_dp_reg;
            end
            // Delay by one so the pulse lines up with the first output cycle of digit 0.
            wrap_reg  <= wrap;
            frame_reg <= wrap_reg;
            an_reg    <= an_next;
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
        end
    end

    assign an_no   = an_reg;
    assign seg_no  = seg_reg;
    assign dp_no   = dp_reg;
    assign frame_o = frame_reg;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan (DIGITS=4, REFRESH_DIV=4); blanking expectations follow SEVENSEG_SCAN_LZ_BLANK_EN.
module tb_sevenseg_scan;
    localparam int D     = 4;
    localparam int R     = 4;
    localparam int FRAME = D * R;

    logic        clk      = 1'b0;
    logic        rst_ni   = 1'b1;
    logic [15:0] value_i  = '0;
    logic        load_i   = 1'b0;
    logic [3:0]  dp_i     = '0;
    logic        enable_i = 1'b1;
    logic [6:0]  seg_no;
    logic        dp_no;
    logic [3:0]  an_no;
    logic        frame_o;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] cur_val = '0;
    logic [3:0]  cur_dp  = '0;

    sevenseg_scan #(.DIGITS(D), .REFRESH_DIV(R)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .value_i(value_i), .load_i(load_i),
        .dp_i(dp_i), .enable_i(enable_i), .seg_no(seg_no), .dp_no(dp_no),
        .an_no(an_no), .frame_o(frame_o)
    );

    always #5 clk = ~clk;

    // Positive-logic lit segments, bit 0 = A .. bit 6 = G
    function automatic logic [6:0] glyph_lit(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Queue the expected outputs of one full frame; cycles at or after dark_from are disabled.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input int dark_from, input logic fr0);
        exp_t e;
        int   k;
        logic lit;
        for (int c = 0; c < FRAME; c++) begin
            k   = c / R;
            lit = (c < dark_from);
`ifdef SEVENSEG_SCAN_LZ_BLANK_EN
            if (k != 0 && (v >> (4 * k)) == 16'h0 && !d[k]) lit = 1'b0;
`endif
            e.an  = lit ? ~(4'b0001 << k) : 4'hF;
            e.seg = lit ? ~glyph_lit(v[4*k +: 4]) : 7'h7F;
            e.dp  = lit ? ~d[k] : 1'b1;
            e.fr  = (c == 0) ? fr0 : 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_o !== 1'b1 && n < 2 * FRAME);
        if (frame_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_frame_timeout frame_o=%b required 1 within %0d cycles", tag, frame_o, 2 * FRAME);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        #1 rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({an_no, seg_no, dp_no, frame_o} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_values an=%b seg=%h dp=%b fr=%b required an=1111 seg=7f dp=1 fr=0",
                     an_no, seg_no, dp_no, frame_o);
        end
        rst_ni = 1'b1;
        push_frame(16'h0, 4'h0, FRAME, 1'b0);
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({an_no, seg_no, dp_no, frame_o} !== e) begin
                errors++;
                $display("FAIL reset_scan c=%0d got an=%b seg=%h dp=%b fr=%b want an=%b seg=%h dp=%b fr=%b",
                         c, an_no, seg_no, dp_no, frame_o, e.an, e.seg, e.dp, e.fr);
            end
        end
        $display("reset: first frame after release checked");
        wait_frame("reset");
        push_frame(16'h0, 4'h0, FRAME, 1'b1);
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({an_no, seg_no, dp_no, frame_o} !== e) begin
                errors++;
                $display("FAIL scan c=%0d got an=%b seg=%h dp=%b fr=%b want an=%b seg=%h dp=%b fr=%b",
                         c, an_no, seg_no, dp_no, frame_o, e.an, e.seg, e.dp, e.fr);
            end
        end
        $display("scan: second frame value=0000 checked");
    endtask

    task automatic test_glyphs();
        exp_t        e;
        logic [15:0] vals [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        for (int f = 0; f < 5; f++) begin
            wait_frame("glyph");
            push_frame(cur_val, cur_dp, FRAME, 1'b1);
            for (int c = 0; c < FRAME; c++) begin
                if (c > 0) @(negedge clk);
                e = sb.pop_front();
                checks++;
                if ({an_no, seg_no, dp_no, frame_o} !== e) begin
                    errors++;
                    $display("FAIL glyph val=%h c=%0d got an=%b seg=%h dp=%b fr=%b want an=%b seg=%h dp=%b fr=%b",
                             cur_val, c, an_no, seg_no, dp_no, frame_o, e.an, e.seg, e.dp, e.fr);
                end
                if (c == 5 && f < 4) begin
                    value_i = vals[f];
                    dp_i    = 4'h0;
                    load_i  = 1'b1;
                end else begin
                    load_i = 1'b0;
                end
            end
            $display("glyph: frame value=%h checked", cur_val);
            if (f < 4) begin
                cur_val = vals[f];
                cur_dp  = 4'h0;
            end
        end
    endtask

    // Mid-frame back-to-back loads (last wins), then a load exactly on the wrap cycle.
    task automatic test_tear_free();
        exp_t e;
        for (int f = 0; f < 3; f++) begin
            wait_frame("tear");
            push_frame(cur_val, cur_dp, FRAME, 1'b1);
            for (int c = 0; c < FRAME; c++) begin
                if (c > 0) @(negedge clk);
                e = sb.pop_front();
                checks++;
                if ({an_no, seg_no, dp_no, frame_o} !== e) begin
                    errors++;
                    $display("FAIL tear_free val=%h c=%0d got an=%b seg=%h dp=%b fr=%b want an=%b seg=%h dp=%b fr=%b",
                             cur_val, c, an_no, seg_no, dp_no, frame_o, e.an, e.seg, e.dp, e.fr);
                end
                load_i = 1'b0;
                if (f == 0 && c == 8)  begin value_i = 16'h1111; dp_i = 4'h0; load_i = 1'b1; end
                if (f == 0 && c == 9)  begin value_i = 16'h1234; dp_i = 4'h0; load_i = 1'b1; end
                if (f == 1 && c == 14) begin value_i = 16'h5678; dp_i = 4'h0; load_i = 1'b1; end
            end
            $display("tear_free: frame value=%h checked", cur_val);
            if (f == 0) cur_val = 16'h1234;
            if (f == 1) cur_val = 16'h5678;
            cur_dp = 4'h0;
        end
    endtask

    task automatic test_enable_dp();
        exp_t e;
        int   dark_from;
        for (int f = 0; f < 3; f++) begin
            wait_frame("enable");
            dark_from = (f == 0) ? FRAME : (f == 1) ? 8 : 0;
            push_frame(cur_val, cur_dp, dark_from, 1'b1);
            for (int c = 0; c < FRAME; c++) begin
                if (c > 0) @(negedge clk);
                e = sb.pop_front();
                checks++;
                if ({an_no, seg_no, dp_no, frame_o} !== e) begin
                    errors++;
                    $display("FAIL enable_dp f=%0d c=%0d got an=%b seg=%h dp=%b fr=%b want an=%b seg=%h dp=%b fr=%b",
                             f, c, an_no, seg_no, dp_no, frame_o, e.an, e.seg, e.dp, e.fr);
                end
                load_i = 1'b0;
                if (f == 0 && c == 5) begin value_i = 16'h1234; dp_i = 4'b0100; load_i = 1'b1; end
                if (f == 1 && c == 7) enable_i = 1'b0;
                if (f == 2 && c == 15) enable_i = 1'b1;
            end
            $display("enable_dp: frame %0d value=%h dp=%b dark_from=%0d checked", f, cur_val, cur_dp, dark_from);
            if (f == 0) begin
                cur_val = 16'h1234;
                cur_dp  = 4'b0100;
            end
        end
    endtask

    task automatic test_blanking();
        exp_t        e;
        logic [15:0] vals [2] = '{16'h0042, 16'h0000};
        for (int f = 0; f < 3; f++) begin
            wait_frame("blank");
            push_frame(cur_val, cur_dp, FRAME, 1'b1);
            for (int c = 0; c < FRAME; c++) begin
                if (c > 0) @(negedge clk);
                e = sb.pop_front();
                checks++;
                if ({an_no, seg_no, dp_no, frame_o} !== e) begin
                    errors++;
                    $display("FAIL blanking val=%h c=%0d got an=%b seg=%h dp=%b fr=%b want an=%b seg=%h dp=%b fr=%b",
                             cur_val, c, an_no, seg_no, dp_no, frame_o, e.an, e.seg, e.dp, e.fr);
                end
                if (c == 5 && f < 2) begin
                    value_i = vals[f];
                    dp_i    = 4'h0;
                    load_i  = 1'b1;
                end else begin
                    load_i = 1'b0;
                end
            end
            $display("blanking: frame value=%h checked", cur_val);
            if (f < 2) begin
                cur_val = vals[f];
                cur_dp  = 4'h0;
            end
        end
    endtask

    // Reset during digit 2 with a load still pending; the load must not survive.
    task automatic test_async_reset();
        exp_t e;
        wait_frame("areset");
        push_frame(cur_val, cur_dp, FRAME, 1'b1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({an_no, seg_no, dp_no, frame_o} !== e) begin
                errors++;
                $display("FAIL areset_pre c=%0d got an=%b seg=%h dp=%b fr=%b want an=%b seg=%h dp=%b fr=%b",
                         c, an_no, seg_no, dp_no, frame_o, e.an, e.seg, e.dp, e.fr);
            end
            if (c == 5) begin
                value_i = 16'hABCD;
                dp_i    = 4'hF;
                load_i  = 1'b1;
            end else begin
                load_i = 1'b0;
            end
        end
        sb.delete();
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({an_no, seg_no, dp_no, frame_o} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL areset_async an=%b seg=%h dp=%b fr=%b required an=1111 seg=7f dp=1 fr=0",
                     an_no, seg_no, dp_no, frame_o);
        end
        $display("areset: outputs cleared without a clock edge");
        repeat (2) @(negedge clk);
        rst_ni  = 1'b1;
        cur_val = 16'h0;
        cur_dp  = 4'h0;
        for (int f = 0; f < 2; f++) begin
            if (f == 1) wait_frame("areset");
            push_frame(16'h0, 4'h0, FRAME, (f == 1));
            for (int c = 0; c < FRAME; c++) begin
                if (f == 0 || c > 0) @(negedge clk);
                e = sb.pop_front();
                checks++;
                if ({an_no, seg_no, dp_no, frame_o} !== e) begin
                    errors++;
                    $display("FAIL areset_post f=%0d c=%0d got an=%b seg=%h dp=%b fr=%b want an=%b seg=%h dp=%b fr=%b",
                             f, c, an_no, seg_no, dp_no, frame_o, e.an, e.seg, e.dp, e.fr);
                end
            end
            $display("areset: post-release frame %0d value=0000 checked", f);
        end
    endtask

    initial begin
        test_reset();
        test_glyphs();
        test_tear_free();
        test_enable_dp();
        test_blanking();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
